bus_arbiter: RTL

Parametrised Wishbone-classic bus front end that replaces the core's single fixed memory port with `NUM_PORTS` independent requesters, such as instruction fetch, load/store and a debug or DMA master. It arbitrates round-robin, registers one transaction at a time onto the shared bus, and returns read data and completion per port. A cycle-count watchdog converts a missing `ack_i` into a per-port bus-error pulse, which the controller maps to an access-fault exception. It sits between the core's controller and data path on one side and the system bus on the other.

---
 rtl/bus_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/bus_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared state/outcome types and index-width helper for the bus arbiter
package bus_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} bus_state_t;
  typedef enum logic {OK, ERR} bus_outcome_t;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last grant
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int GW = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [GW-1:0]        last_i,
  output logic [GW-1:0]        grant_o,
  output logic                 valid_o
);
  // scan downward so the nearest requester after last_i is written last and wins
  always_comb begin
    logic [GW-1:0] idx;
    idx = '0;
    grant_o = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = GW'((int'(last_i) + i) % NUM_PORTS);
      if (req_i[idx]) grant_o = idx;
    end
    valid_o = |req_i;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin multi-port Wishbone-classic front end with ack watchdog
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_WIDTH = DATA_WIDTH / 8,
  localparam int GW = idx_width(NUM_PORTS),
  localparam int CW = idx_width(TIMEOUT_CYCLES + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  req_we_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_adr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_PORTS-1:0][SEL_WIDTH-1:0]   req_sel_i,
  output logic [NUM_PORTS-1:0]                  done_o,
  output logic [NUM_PORTS-1:0]                  err_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  input  logic                                  ack_i,
  input  logic [DATA_WIDTH-1:0]                 data_i,
  output logic [ADDR_WIDTH-1:0]                 adr_o,
  output logic [DATA_WIDTH-1:0]                 data_o,
  output logic [SEL_WIDTH-1:0]                  sel_o,
  output logic                                  we_o,
  output logic                                  stb_o,
  output logic [1:0]                            debug_state,
  output logic [GW-1:0]                         debug_grant
);
  bus_state_t             state_q;
  bus_outcome_t           outcome_q;
  logic [GW-1:0]          grant_q;
  logic [CW-1:0]          cnt_q;
  logic                   stb_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  adr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [GW-1:0]          grant_d;
  logic                   valid_d;
  logic [NUM_PORTS-1:0]   port_hot;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req_i  (req_i),
    .last_i (grant_q),
    .grant_o(grant_d),
    .valid_o(valid_d)
  );

  // grant_q doubles as last_grant: it only changes at a new grant, so in IDLE it is the last served port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      outcome_q <= OK;
      grant_q   <= GW'(NUM_PORTS - 1);
      cnt_q     <= '0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid_d) begin
          grant_q <= grant_d;
          we_q    <= req_we_i[grant_d];
          adr_q   <= req_adr_i[grant_d];
          data_q  <= req_data_i[grant_d];
          sel_q   <= req_sel_i[grant_d];
          stb_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= BUS;
        end
        BUS: if (ack_i) begin
          if (!we_q) rdata_q <= data_i;
          stb_q     <= 1'b0;
          outcome_q <= OK;
          state_q   <= RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          stb_q     <= 1'b0;
          outcome_q <= ERR;
          state_q   <= RESP;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign port_hot    = NUM_PORTS'(1) << grant_q;
  assign done_o      = (state_q == RESP && outcome_q == OK) ? port_hot : '0;
  assign err_o       = (state_q == RESP && outcome_q == ERR) ? port_hot : '0;
  assign rdata_o     = rdata_q;
  assign adr_o       = adr_q;
  assign data_o      = data_q;
  assign sel_o       = sel_q;
  assign we_o        = we_q;
  assign stb_o       = stb_q;
  assign debug_state = state_q;
  assign debug_grant = grant_q;
endmodule
